// File: rtl/lcd1602_bus_reader.sv
// Read-side transactor for the HD44780/LCD1602 bus: runs RS/RW/E read cycles and
// optionally repeats busy-flag reads until BF clears or the poll budget runs out.
module lcd1602_bus_reader #(
  parameter int T_AS      = 3,
  parameter int T_PW      = 25,
  parameter int T_H       = 2,
  parameter int T_GAP     = 20,
  parameter int MAX_POLLS = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_i,
  input  logic       rs_sel_i,
  input  logic       wait_bf_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       bus_busy_o,
  output logic       done_o,
  output logic [7:0] rd_data_o,
  output logic       busy_flag_o,
  output logic [6:0] addr_o,
  output logic       timeout_o,
  output logic       rs,
  output logic       rw,
  output logic       enable
);

  localparam int T_MAX_A = (T_AS > T_PW) ? T_AS : T_PW;
  localparam int T_MAX_B = (T_H > T_GAP) ? T_H : T_GAP;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int TW      = $clog2(T_MAX + 1);
  localparam int PW      = $clog2(MAX_POLLS + 1);

  // Each phase timer is loaded with (length - 1) and the phase ends when it reaches zero.
  localparam logic [TW-1:0] AS_LD  = TW'(T_AS - 1);
  localparam logic [TW-1:0] PW_LD  = TW'(T_PW - 1);
  localparam logic [TW-1:0] H_LD   = TW'(T_H - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(T_GAP - 1);
  localparam logic [PW-1:0] POLL_MAX = PW'(MAX_POLLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_E_HIGH,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [PW-1:0] poll_cnt;
  logic          sel_q;
  logic          auto_poll_q;

  assign ready_o    = (state == S_IDLE);
  assign bus_busy_o = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every flop, including the read-data registers, is cleared by the async reset so
    // the bus pins drop the instant reset asserts and no stale byte survives it.
    if (!reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      poll_cnt    <= '0;
      sel_q       <= 1'b0;
      auto_poll_q <= 1'b0;
      rs          <= 1'b0;
      rw          <= 1'b0;
      enable      <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
      rd_data_o   <= '0;
      busy_flag_o <= 1'b0;
      addr_o      <= '0;
    end else begin
      // NOTE: done_o defaults low every cycle (non-blocking, last assignment wins), so it can
      // only ever be a single-cycle pulse.
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_i) begin
            sel_q       <= rs_sel_i;
            auto_poll_q <= wait_bf_i & ~rs_sel_i;
            timeout_o   <= 1'b0;
            poll_cnt    <= PW'(1);
            timer       <= AS_LD;
            rs          <= rs_sel_i;
            rw          <= 1'b1;
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (timer == '0) begin
            enable <= 1'b1;
            timer  <= PW_LD;
            state  <= S_E_HIGH;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_E_HIGH: begin
          if (timer == '0) begin
            enable    <= 1'b0;
            rd_data_o <= data_i;
            if (!sel_q) begin
              busy_flag_o <= data_i[7];
              addr_o      <= data_i[6:0];
            end
            timer <= H_LD;
            state <= S_HOLD;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_HOLD: begin
          if (timer == '0) begin
            rs    <= 1'b0;
            rw    <= 1'b0;
            timer <= GAP_LD;
            state <= S_GAP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_GAP: begin
          if (timer == '0) begin
            if (auto_poll_q && rd_data_o[7] && (poll_cnt != POLL_MAX)) begin
              poll_cnt <= poll_cnt + PW'(1);
              rs       <= sel_q;
              rw       <= 1'b1;
              timer    <= AS_LD;
              state    <= S_SETUP;
            end else begin
              // Reaching here with BF still set under auto-poll means the budget is spent.
              timeout_o <= auto_poll_q & rd_data_o[7];
              done_o    <= 1'b1;
              state     <= S_IDLE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd1602_bus_reader.sv
// Directed bench for lcd1602_bus_reader (MAX_POLLS=4); samples on the falling edge,
// where sample k follows the k-th rising edge after the accepting edge.
module tb_lcd1602_bus_reader;

  logic       clk;
  logic       reset;
  logic       req_i;
  logic       rs_sel_i;
  logic       wait_bf_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       bus_busy_o;
  logic       done_o;
  logic [7:0] rd_data_o;
  logic       busy_flag_o;
  logic [6:0] addr_o;
  logic       timeout_o;
  logic       rs;
  logic       rw;
  logic       enable;

  int checks   = 0;
  int failures = 0;

  lcd1602_bus_reader #(
    .T_AS(3), .T_PW(25), .T_H(2), .T_GAP(20), .MAX_POLLS(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req_i),
    .rs_sel_i   (rs_sel_i),
    .wait_bf_i  (wait_bf_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .bus_busy_o (bus_busy_o),
    .done_o     (done_o),
    .rd_data_o  (rd_data_o),
    .busy_flag_o(busy_flag_o),
    .addr_o     (addr_o),
    .timeout_o  (timeout_o),
    .rs         (rs),
    .rw         (rw),
    .enable     (enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request; checks the bus waveform against the fixed 50-cycle read period
  // (SETUP 0..2, E 3..27, HOLD 28..29, GAP 30..49). BF byte is driven for bf_reads reads.
  task automatic run_txn(input logic sel, input logic wbf, input int bf_reads,
                         input logic [7:0] bf_byte, input logic [7:0] final_byte,
                         output int done_k, output int pulses, output int bus_err,
                         output logic to_done, output logic to_k0);
    logic prev_en;
    logic exp_en, exp_rw, exp_rs;
    int   k, phase;
    done_k = -1; pulses = 0; bus_err = 0; to_done = 1'b0; to_k0 = 1'b1; prev_en = 1'b0;
    @(negedge clk);
    req_i = 1'b1; rs_sel_i = sel; wait_bf_i = wbf;
    data_i = (bf_reads > 0) ? bf_byte : final_byte;
    @(posedge clk);
    k = 0;
    while (done_k < 0 && k < 1000) begin
      @(negedge clk);
      if (k == 0) begin
        req_i = 1'b0; rs_sel_i = ~sel; wait_bf_i = ~wbf;
        to_k0 = timeout_o;
      end
      if (done_o) begin
        done_k  = k;
        to_done = timeout_o;
      end else begin
        phase  = k % 50;
        exp_en = (phase >= 3) && (phase <= 27);
        exp_rw = (phase < 30);
        exp_rs = sel & exp_rw;
        if (enable !== exp_en || rw !== exp_rw || rs !== exp_rs ||
            bus_busy_o !== 1'b1 || ready_o !== 1'b0) bus_err++;
      end
      if (enable && !prev_en) pulses++;
      if (!enable && prev_en && pulses == bf_reads) data_i = final_byte;
      prev_en = enable;
      k++;
    end
  endtask

  int   done_k, pulses, bus_err;
  logic to_done, to_k0;
  int   first_done, second_done, done_cnt, en_cnt;
  logic busy_51, rw_51, idle_after;

  initial begin
    reset = 1'b0; req_i = 1'b0; rs_sel_i = 1'b0; wait_bf_i = 1'b0; data_i = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_pins", {29'd0, rs, rw, enable}, 32'd0);
    check("rst_flags", {29'd0, done_o, timeout_o, busy_flag_o}, 32'd0);
    check("rst_data", {17'd0, addr_o, rd_data_o}, 32'd0);
    check("rst_ready", {30'd0, ready_o, bus_busy_o}, 32'd2);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: busy-flag/address read, single shot
    run_txn(1'b0, 1'b0, 0, 8'h00, 8'h45, done_k, pulses, bus_err, to_done, to_k0);
    check("t1_done_k", done_k, 50);
    check("t1_pulses", pulses, 1);
    check("t1_bus", bus_err, 0);
    check("t1_timeout", {31'd0, to_done}, 0);
    check("t1_rd", {24'd0, rd_data_o}, 32'h45);
    check("t1_bf_addr", {24'd0, busy_flag_o, addr_o}, 32'h45);
    check("t1_ready_done", {30'd0, ready_o, bus_busy_o}, 32'd2);
    @(negedge clk);
    check("t1_done_pulse", {31'd0, done_o}, 0);

    // 2: DDRAM read with wait_bf set (ignored); BF bit in data must not trigger polling
    run_txn(1'b1, 1'b1, 0, 8'h00, 8'hC1, done_k, pulses, bus_err, to_done, to_k0);
    check("t2_done_k", done_k, 50);
    check("t2_pulses", pulses, 1);
    check("t2_bus", bus_err, 0);
    check("t2_rd", {24'd0, rd_data_o}, 32'hC1);
    check("t2_bf_addr", {24'd0, busy_flag_o, addr_o}, 32'h45);

    // 3: auto-poll, BF=1 for three reads then clears
    run_txn(1'b0, 1'b1, 3, 8'hA5, 8'h07, done_k, pulses, bus_err, to_done, to_k0);
    check("t3_done_k", done_k, 200);
    check("t3_pulses", pulses, 4);
    check("t3_bus", bus_err, 0);
    check("t3_timeout", {31'd0, to_done}, 0);
    check("t3_bf_addr", {24'd0, busy_flag_o, addr_o}, 32'h07);

    // 4: BF stuck high, poll budget of 4 exhausted
    run_txn(1'b0, 1'b1, 100, 8'hFF, 8'hFF, done_k, pulses, bus_err, to_done, to_k0);
    check("t4_done_k", done_k, 200);
    check("t4_pulses", pulses, 4);
    check("t4_bus", bus_err, 0);
    check("t4_timeout", {31'd0, to_done}, 1);
    check("t4_bf_addr", {24'd0, busy_flag_o, addr_o}, 32'hFF);
    @(negedge clk);
    check("t4_timeout_hold", {31'd0, timeout_o}, 1);
    run_txn(1'b1, 1'b0, 0, 8'h00, 8'h3C, done_k, pulses, bus_err, to_done, to_k0);
    check("t4b_timeout_clr", {31'd0, to_k0}, 0);
    check("t4b_rd", {24'd0, rd_data_o}, 32'h3C);
    check("t4b_bf_addr", {24'd0, busy_flag_o, addr_o}, 32'hFF);

    // 5: reset asserted in the middle of E high
    @(negedge clk);
    req_i = 1'b1; rs_sel_i = 1'b1; wait_bf_i = 1'b0; data_i = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_pre_pins", {29'd0, rs, rw, enable}, 32'd7);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_pins", {29'd0, rs, rw, enable}, 32'd0);
    check("t5_rst_ready", {30'd0, ready_o, bus_busy_o}, 32'd2);
    check("t5_rst_rd", {24'd0, rd_data_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    done_cnt = 0; en_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done_o) done_cnt++;
      if (enable) en_cnt++;
    end
    check("t5_no_done", done_cnt, 0);
    check("t5_no_enable", en_cnt, 0);
    check("t5_ready", {31'd0, ready_o}, 1);

    // 6: req held across done (back-to-back accept), then req pulsed during GAP
    @(negedge clk);
    req_i = 1'b1; rs_sel_i = 1'b0; wait_bf_i = 1'b0; data_i = 8'h12;
    @(posedge clk);
    first_done = -1; second_done = -1; done_cnt = 0;
    busy_51 = 1'b0; rw_51 = 1'b0; idle_after = 1'b1;
    for (int k = 0; k < 108; k++) begin
      @(negedge clk);
      if (done_o) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
        else if (second_done < 0) second_done = k;
      end
      if (k == 51) begin
        busy_51 = bus_busy_o; rw_51 = rw; req_i = 1'b0;
      end
      if (k == 86) req_i = 1'b1;
      if (k == 87) req_i = 1'b0;
      if (k > 101 && bus_busy_o !== 1'b0) idle_after = 1'b0;
    end
    check("t6_first_done", first_done, 50);
    check("t6_reaccept", {30'd0, busy_51, rw_51}, 32'd3);
    check("t6_second_done", second_done, 101);
    check("t6_done_cnt", done_cnt, 2);
    check("t6_gap_req_ignored", {31'd0, idle_after}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
